lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit of the 5-stage RV32I core. Sits between the EX/MEM register and the MEM/WB register.
- Contains the byte-enabled data memory and the memory-mapped I/O output registers (LEDs, 7-seg, LCD), plus a synchronizer for the switch inputs.
- Produces the aligned, extended load data and the I/O values that the MEM/WB register captures.

Parameters:
- DMEM_BASE, 32'h0000_2000, byte base address of data memory
- DMEM_AW, 11, word-address width of data memory (2048 words = 8 KiB)
- SW_SYNC_STAGES, 2, flip-flop stages on i_io_sw

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_enable_mem  in  1  pipeline advance; 0 = stall, no state change
- i_inst_vld_mem  in  1  instruction valid; 0 = bubble/flushed, no side effects
- i_lsu_wren  in  1  store request
- i_lsu_rden  in  1  load request
- i_funct3  in  3  access size/sign (RV32I load/store funct3)
- i_lsu_addr  in  32  byte address (ALU result)
- i_st_data  in  32  store data (rs2)
- i_io_sw  in  32  raw switch inputs, asynchronous
- o_ld_data  out  32  extended load result, combinational
- o_lsu_err  out  1  misaligned or illegal funct3 on a valid access, combinational
- o_io_ledr, o_io_ledg, o_io_lcd  out  32 each  I/O output registers
- o_io_hex0 .. o_io_hex7  out  7 each  7-segment output registers

Behaviour:
- Address map:
  - DMEM: DMEM_BASE .. DMEM_BASE + 4*2^DMEM_AW - 1
  - LEDR 0x7000; LEDG 0x7010
  - HEXLO 0x7020: hex0..3 in bits [6:0], [14:8], [22:16], [30:24]
  - HEXHI 0x7024: hex4..7, same lane layout
  - LCD 0x7030
  - SW 0x7800, read-only
  - Every other address: reads return 0, writes are dropped.
- Access is effective only when i_inst_vld_mem & i_enable_mem & !i_reset & !o_lsu_err.
- funct3 encoding:
  - 000: byte
  - 001: half
  - 010: word
  - 100: byte unsigned
  - 101: half unsigned
  - 011, 110, 111: illegal. Set o_lsu_err when a request is active; load returns 0; store dropped.
- Alignment:
  - Half requires addr[0] = 0; word requires addr[1:0] = 00.
  - A violation sets o_lsu_err (only when i_inst_vld_mem & (i_lsu_wren | i_lsu_rden)), forces o_ld_data to 0, and drops the store.
  - No exception is raised.
- Stores:
  - Written at the rising edge after an effective store.
  - The store data lane is replicated; byte enables select addr[1:0] lanes. SB writes 1 lane, SH 2 lanes, SW 4 lanes.
  - Partial stores to I/O registers update only the enabled lanes.
  - Writes to SW are ignored.
- Loads:
  - Combinational (async read) from the addressed word.
  - Lane selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Reading an I/O output register returns its current value. SW returns the synchronized value.
- Read and write to the same address in the same cycle cannot occur (one request per instruction).
- A store at cycle N is visible to a load at cycle N+1.
- i_lsu_wren and i_lsu_rden both high: treated as a store, o_ld_data = 0.
- Stall (i_enable_mem = 0): memory and I/O registers hold; the switch synchronizer keeps sampling.
- Reset:
  - All I/O output registers reset to 0; switch synchronizer stages reset to 0.
  - DMEM contents are not reset.
  - A store presented in the same cycle as i_reset is dropped.
  - Reset mid-stall clears the I/O registers regardless of i_enable_mem.
- Latency:
  - Store effect: 1 cycle.
  - Load data: 0 cycles (captured by MEM/WB).
  - SW input to visibility: SW_SYNC_STAGES cycles.

Decomposition:
- Package lsu_pkg:
  - Address constants: LEDR, LEDG, HEXLO, HEXHI, LCD, SW.
  - funct3 enum: LB, LH, LW, LBU, LHU.
  - Region decode enum: DMEM, IO_LEDR, IO_LEDG, IO_HEXLO, IO_HEXHI, IO_LCD, IO_SW, NONE.
- Sub-module lsu_dmem:
  - Word array with 4 byte-write enables, synchronous write, async read.
  - Depth 2^DMEM_AW; no reset.

Test Plan:
- SW 0xDEADBEEF to 0x2000, then LW 0x2000 -> 0xDEADBEEF. Then SB 0x55 to 0x2001, LW -> 0xDEAD55EF, LB 0x2003 -> 0xFFFFFFDE, LBU 0x2003 -> 0x000000DE.
- SH 0x8001 to 0x2002, LH 0x2002 -> 0xFFFF8001, LHU -> 0x00008001. LH at 0x2001 -> o_lsu_err = 1, o_ld_data = 0. SH at 0x2003 -> err, memory unchanged.
- SW 0x7F3F067F to 0x7020 -> hex0 = 7F, hex1 = 06, hex2 = 3F, hex3 = 7F, next cycle. SB 0x40 to 0x7021 -> only hex1 = 40.
- i_io_sw = 0x00000A5A, wait 2 cycles, LW 0x7800 -> 0x00000A5A. SW 0xFFFFFFFF to 0x7800 -> no effect.
- Store with i_inst_vld_mem = 0, or with i_enable_mem = 0 -> LEDR, LEDG, LCD and DMEM unchanged.
- LEDR = 0x3FF, assert i_reset 1 cycle while a store of 0x1 to 0x7000 is presented -> o_io_ledr = 0 after the edge. A DMEM word written before reset still reads back unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg: shared address map, access-size encodings and byte-lane helpers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [31:0] LEDR  = 32'h0000_7000;
  localparam logic [31:0] LEDG  = 32'h0000_7010;
  localparam logic [31:0] HEXLO = 32'h0000_7020;
  localparam logic [31:0] HEXHI = 32'h0000_7024;
  localparam logic [31:0] LCD   = 32'h0000_7030;
  localparam logic [31:0] SW    = 32'h0000_7800;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    DMEM,
    IO_LEDR,
    IO_LEDG,
    IO_HEXLO,
    IO_HEXHI,
    IO_LCD,
    IO_SW,
    NONE
  } region_e;

  // size: 00 byte, 01 half, 1x word; lane chosen by the low address bits
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    for (int b = 0; b < 4; b++) begin
      merge_bytes[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_dmem.sv
// ----------------------------------------------------------------------------
// lsu_dmem: byte-writable word RAM, synchronous write, asynchronous read. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_dmem #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [3:0][7:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][b] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage: RV32I MEM-stage load/store unit with data memory and MMIO. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE      = 32'h0000_2000,
  parameter int          DMEM_AW        = 11,
  parameter int          SW_SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable_mem,
  input  logic        i_inst_vld_mem,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_err,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  funct3_e    w_f3;
  region_e    w_region;
  logic       w_req;
  logic       w_f3_legal;
  logic       w_misalign;
  logic       w_store;
  logic [29:0] w_dmem_woff;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_dmem_rdata;
  logic [31:0] w_rword;
  logic [31:0] w_lane;

  logic [31:0]     ledr_q, ledr_d;
  logic [31:0]     ledg_q, ledg_d;
  logic [31:0]     lcd_q, lcd_d;
  logic [3:0][6:0] hex_lo_q, hex_lo_d;
  logic [3:0][6:0] hex_hi_q, hex_hi_d;
  logic [SW_SYNC_STAGES-1:0][31:0] sw_sync_q;

  assign w_f3       = funct3_e'(i_funct3);
  assign w_req      = i_lsu_wren | i_lsu_rden;
  assign w_f3_legal = (i_funct3 == LB) || (i_funct3 == LH) || (i_funct3 == LW) ||
                      (i_funct3 == LBU) || (i_funct3 == LHU);
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_lsu_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_lsu_addr[1:0] != 2'b00));
  assign o_lsu_err  = i_inst_vld_mem && w_req && (!w_f3_legal || w_misalign);
  assign w_store    = i_inst_vld_mem && i_enable_mem && !i_reset && !o_lsu_err && i_lsu_wren;

  assign w_be    = byte_en(i_funct3[1:0], i_lsu_addr[1:0]);
  assign w_wdata = (i_funct3[1:0] == 2'b00) ? {4{i_st_data[7:0]}} :
                   (i_funct3[1:0] == 2'b01) ? {2{i_st_data[15:0]}} : i_st_data;

  // Word-granular offset: unsigned wrap makes addresses below the base fall out of range too.
  assign w_dmem_woff = i_lsu_addr[31:2] - DMEM_BASE[31:2];

  always_comb begin
    w_region = NONE;
    if (w_dmem_woff[29:DMEM_AW] == '0) begin
      w_region = DMEM;
    end else begin
      case (i_lsu_addr[31:2])
        LEDR[31:2]:  w_region = IO_LEDR;
        LEDG[31:2]:  w_region = IO_LEDG;
        HEXLO[31:2]: w_region = IO_HEXLO;
        HEXHI[31:2]: w_region = IO_HEXHI;
        LCD[31:2]:   w_region = IO_LCD;
        SW[31:2]:    w_region = IO_SW;
        default:     w_region = NONE;
      endcase
    end
  end

  lsu_dmem #(
    .AW (DMEM_AW)
  ) u_dmem (
    .clk_i   (i_clk),
    .we_i    (w_store && (w_region == DMEM)),
    .be_i    (w_be),
    .addr_i  (w_dmem_woff[DMEM_AW-1:0]),
    .wdata_i (w_wdata),
    .rdata_o (w_dmem_rdata)
  );

  always_comb begin
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    lcd_d    = lcd_q;
    hex_lo_d = hex_lo_q;
    hex_hi_d = hex_hi_q;
    if (w_store) begin
      case (w_region)
        IO_LEDR: ledr_d = merge_bytes(ledr_q, w_wdata, w_be);
        IO_LEDG: ledg_d = merge_bytes(ledg_q, w_wdata, w_be);
        IO_LCD:  lcd_d  = merge_bytes(lcd_q, w_wdata, w_be);
        IO_HEXLO: begin
          for (int i = 0; i < 4; i++) if (w_be[i]) hex_lo_d[i] = w_wdata[8*i +: 7];
        end
        IO_HEXHI: begin
          for (int i = 0; i < 4; i++) if (w_be[i]) hex_hi_d[i] = w_wdata[8*i +: 7];
        end
        default: ;
      endcase
    end
  end

  // Reset overrides the stall so a held pipeline still comes up with clean I/O.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr_q    <= '0;
      ledg_q    <= '0;
      lcd_q     <= '0;
      hex_lo_q  <= '0;
      hex_hi_q  <= '0;
      sw_sync_q <= '0;
    end else begin
      ledr_q       <= ledr_d;
      ledg_q       <= ledg_d;
      lcd_q        <= lcd_d;
      hex_lo_q     <= hex_lo_d;
      hex_hi_q     <= hex_hi_d;
      sw_sync_q[0] <= i_io_sw;
      for (int k = 1; k < SW_SYNC_STAGES; k++) sw_sync_q[k] <= sw_sync_q[k-1];
    end
  end

  always_comb begin
    case (w_region)
      DMEM:     w_rword = w_dmem_rdata;
      IO_LEDR:  w_rword = ledr_q;
      IO_LEDG:  w_rword = ledg_q;
      IO_LCD:   w_rword = lcd_q;
      IO_HEXLO: w_rword = {1'b0, hex_lo_q[3], 1'b0, hex_lo_q[2], 1'b0, hex_lo_q[1], 1'b0, hex_lo_q[0]};
      IO_HEXHI: w_rword = {1'b0, hex_hi_q[3], 1'b0, hex_hi_q[2], 1'b0, hex_hi_q[1], 1'b0, hex_hi_q[0]};
      IO_SW:    w_rword = sw_sync_q[SW_SYNC_STAGES-1];
      default:  w_rword = '0;
    endcase
  end

  assign w_lane = w_rword >> {i_lsu_addr[1:0], 3'b000};

  always_comb begin
    o_ld_data = '0;
    if (i_lsu_rden && !i_lsu_wren && !o_lsu_err) begin
      case (w_f3)
        LB:      o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
        LH:      o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
        LW:      o_ld_data = w_lane;
        LBU:     o_ld_data = {24'h0, w_lane[7:0]};
        LHU:     o_ld_data = {16'h0, w_lane[15:0]};
        default: o_ld_data = '0;
      endcase
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_lo_q[0];
  assign o_io_hex1 = hex_lo_q[1];
  assign o_io_hex2 = hex_lo_q[2];
  assign o_io_hex3 = hex_lo_q[3];
  assign o_io_hex4 = hex_hi_q[0];
  assign o_io_hex5 = hex_hi_q[1];
  assign o_io_hex6 = hex_hi_q[2];
  assign o_io_hex7 = hex_hi_q[3];

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_stage: directed self-checking bench for the MEM-stage LSU. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_mem;
  logic        inst_vld;
  logic        wren;
  logic        rden;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] io_sw;
  logic [31:0] ld_data;
  logic        lsu_err;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable_mem   (enable_mem),
    .i_inst_vld_mem (inst_vld),
    .i_lsu_wren     (wren),
    .i_lsu_rden     (rden),
    .i_funct3       (funct3),
    .i_lsu_addr     (addr),
    .i_st_data      (st_data),
    .i_io_sw        (io_sw),
    .o_ld_data      (ld_data),
    .o_lsu_err      (lsu_err),
    .o_io_ledr      (ledr),
    .o_io_ledg      (ledg),
    .o_io_lcd       (lcd),
    .o_io_hex0      (hex0),
    .o_io_hex1      (hex1),
    .o_io_hex2      (hex2),
    .o_io_hex3      (hex3),
    .o_io_hex4      (hex4),
    .o_io_hex5      (hex5),
    .o_io_hex6      (hex6),
    .o_io_hex7      (hex7)
  );

  // Inputs change on the falling edge; outputs are read 1 ns later, far from the rising edge.
  task automatic drive(input logic vld, input logic en, input logic we, input logic re,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    inst_vld   = vld;
    enable_mem = en;
    wren       = we;
    rden       = re;
    funct3     = f3;
    addr       = a;
    st_data    = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    rst = 1'b0;
    checks++;
    if ({ledr, ledg, lcd} !== 96'h0) begin
      errors++;
      $display("FAIL reset_io got %h expected 0", {ledr, ledg, lcd});
    end
    checks++;
    if ({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} !== 56'h0) begin
      errors++;
      $display("FAIL reset_hex got %h expected 0", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0});
    end
  endtask

  task automatic test_dmem_bytes;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h2000, 32'hDEADBEEF);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h2000, 32'h0);
    checks++;
    if (ld_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_word got %h expected DEADBEEF", ld_data);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h2001, 32'h00000055);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h2000, 32'h0);
    checks++;
    if (ld_data !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_merge got %h expected DEAD55EF", ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h2003, 32'h0);
    checks++;
    if (ld_data !== 32'hFFFFFFDE) begin
      errors++;
      $display("FAIL lb_sign got %h expected FFFFFFDE", ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h2003, 32'h0);
    checks++;
    if (ld_data !== 32'h000000DE) begin
      errors++;
      $display("FAIL lbu_zero got %h expected 000000DE", ld_data);
    end
  endtask

  task automatic test_half_and_align;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h00008001);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h2002, 32'h0);
    checks++;
    if (ld_data !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_sign got %h expected FFFF8001", ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'h2002, 32'h0);
    checks++;
    if (ld_data !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu_zero got %h expected 00008001", ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h2001, 32'h0);
    checks++;
    if ({lsu_err, ld_data} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL lh_misalign got err=%b data=%h expected err=1 data=0", lsu_err, ld_data);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h2003, 32'h00001234);
    checks++;
    if (lsu_err !== 1'b1) begin
      errors++;
      $display("FAIL sh_misalign_err got %b expected 1", lsu_err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h2000, 32'h0);
    checks++;
    if ({lsu_err, ld_data} !== {1'b0, 32'h800155EF}) begin
      errors++;
      $display("FAIL sh_misalign_dropped got err=%b data=%h expected err=0 data=800155EF", lsu_err, ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 32'h2000, 32'h0);
    checks++;
    if ({lsu_err, ld_data} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL illegal_f3 got err=%b data=%h expected err=1 data=0", lsu_err, ld_data);
    end
  endtask

  task automatic test_hex;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7020, 32'h7F3F067F);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if ({hex3, hex2, hex1, hex0} !== {7'h7F, 7'h3F, 7'h06, 7'h7F}) begin
      errors++;
      $display("FAIL hexlo_word got %h %h %h %h expected 7f 3f 06 7f", hex3, hex2, hex1, hex0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h7021, 32'h00000040);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h7020, 32'h0);
    checks++;
    if ({hex3, hex2, hex1, hex0} !== {7'h7F, 7'h3F, 7'h40, 7'h7F}) begin
      errors++;
      $display("FAIL hexlo_sb got %h %h %h %h expected 7f 3f 40 7f", hex3, hex2, hex1, hex0);
    end
    checks++;
    if (ld_data !== 32'h7F3F407F) begin
      errors++;
      $display("FAIL hexlo_read got %h expected 7F3F407F", ld_data);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h7026, 32'h00000B0C);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if ({hex7, hex6, hex5, hex4} !== {7'h0B, 7'h0C, 7'h00, 7'h00}) begin
      errors++;
      $display("FAIL hexhi_sh got %h %h %h %h expected 0b 0c 00 00", hex7, hex6, hex5, hex4);
    end
  endtask

  task automatic test_switches;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h7800, 32'h0);
    io_sw = 32'h00000A5A;
    @(negedge clk);
    #1;
    checks++;
    if (ld_data !== 32'h0) begin
      errors++;
      $display("FAIL sw_one_stage got %h expected 0", ld_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ld_data !== 32'h00000A5A) begin
      errors++;
      $display("FAIL sw_synced got %h expected 00000A5A", ld_data);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7800, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h7800, 32'h0);
    checks++;
    if (ld_data !== 32'h00000A5A) begin
      errors++;
      $display("FAIL sw_readonly got %h expected 00000A5A", ld_data);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h7040, 32'h0);
    checks++;
    if ({lsu_err, ld_data} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL unmapped_read got err=%b data=%h expected err=0 data=0", lsu_err, ld_data);
    end
  endtask

  task automatic test_gating;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h00000123);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h7010, 32'h00000456);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h7030, 32'h00000789);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h00000000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h11111111);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h2000, 32'h0);
    checks++;
    if ({ledr, ledg, lcd} !== 96'h0) begin
      errors++;
      $display("FAIL gated_io got %h expected 0", {ledr, ledg, lcd});
    end
    checks++;
    if (ld_data !== 32'h800155EF) begin
      errors++;
      $display("FAIL gated_dmem got %h expected 800155EF", ld_data);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7030, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h7030, 32'h00000001);
    checks++;
    if ({lcd, ld_data} !== {32'hCAFEF00D, 32'h0}) begin
      errors++;
      $display("FAIL lcd_then_rw got lcd=%h data=%h expected lcd=CAFEF00D data=0", lcd, ld_data);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if (lcd !== 32'h00000001) begin
      errors++;
      $display("FAIL rw_as_store got %h expected 00000001", lcd);
    end
  endtask

  task automatic test_reset_store;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h000003FF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if (ledr !== 32'h000003FF) begin
      errors++;
      $display("FAIL ledr_set got %h expected 000003FF", ledr);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'h00000001);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ledr !== 32'h0) begin
      errors++;
      $display("FAIL reset_drops_store got %h expected 0", ledr);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h7030, 32'h0000ABCD);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checks++;
    if (lcd !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL lcd_before_stall_reset got %h expected 0000ABCD", lcd);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (lcd !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_stall got %h expected 0", lcd);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h2000, 32'h0);
    checks++;
    if (ld_data !== 32'h800155EF) begin
      errors++;
      $display("FAIL dmem_survives_reset got %h expected 800155EF", ld_data);
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable_mem = 1'b1;
    inst_vld   = 1'b0;
    wren       = 1'b0;
    rden       = 1'b0;
    funct3     = 3'b010;
    addr       = 32'h0;
    st_data    = 32'h0;
    io_sw      = 32'h0;
    test_reset();
    test_dmem_bytes();
    test_half_and_align();
    test_hex();
    test_switches();
    test_gating();
    test_reset_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
